// File: rtl/bus_arbiter_if.sv
// Datapath bus arbitration bundle: requester-side request/source fields and arbiter-side grant/decode outputs.
// Requesters use the master modport; the arbiter uses the slave modport.
interface bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 5,
    parameter int N_SRC = 24
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SRC_W-1:0] req_src;
    logic [N_REQ-1:0]       gnt;
    logic [N_SRC-1:0]       bus_out_en;
    logic                   busy;
    logic                   timeout;
    logic                   bad_src;

    modport master (
        output req, req_src,
        input  gnt, bus_out_en, busy, timeout, bad_src
    );

    modport slave (
        input  req, req_src,
        output gnt, bus_out_en, busy, timeout, bad_src
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin datapath bus arbiter with hold-time preemption and one-hot source drive-enable decode.
// Grant appears one cycle after request; requesters wait on level req until granted, drive enables follow req_src combinationally.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SRC_W    = 5,
    parameter int N_SRC    = 24,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          clr,
    bus_arbiter_if.slave  bus
);
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE_REQ   = N_REQ'(1);
    localparam logic [N_SRC-1:0]  ONE_SRC   = N_SRC'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;

    logic [N_REQ-1:0]    owner_oh;
    logic [N_REQ-1:0]    others;
    logic [SRC_W-1:0]    src;
    logic                src_bad;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + PTR_W'(1);
    endfunction

    // First set bit at or after start, wrapping; callers guarantee r != 0.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] pick;
        logic             found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return pick;
    endfunction

    assign owner_oh = ONE_REQ << owner_q;
    assign others   = bus.req & ~owner_oh;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    owner_d = rr_pick(bus.req, rr_q);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    rr_d   = next_idx(owner_q);
                    hold_d = '0;
                    if (|others) begin
                        owner_d = rr_pick(others, next_idx(owner_q));
                    end else begin
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD > 0 && hold_q == HOLD_LAST && |others) begin
                    // Owner has used its full hold budget while someone else waits.
                    rr_d      = next_idx(owner_q);
                    owner_d   = rr_pick(others, next_idx(owner_q));
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else if (MAX_HOLD > 0 && hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        src            = bus.req_src[int'(owner_q)*SRC_W +: SRC_W];
        src_bad        = (int'(src) >= N_SRC);
        bus.gnt        = (state_q == GRANT) ? owner_oh : '0;
        bus.busy       = (state_q == GRANT);
        bus.timeout    = timeout_q;
        bus.bad_src    = (state_q == GRANT) && src_bad;
        // An out-of-range source leaves the bus undriven rather than aliasing.
        bus.bus_out_en = ((state_q == GRANT) && !src_bad) ? (ONE_SRC << src) : '0;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-cycle expected outputs queued with each stimulus step and popped after the edge.
module tb_bus_arbiter;
    logic clk;
    logic clr;
    int   checks;
    int   passed;
    int   src_tab [4];

    logic [30:0] sb [$];

    bus_arbiter_if #(.N_REQ(4), .SRC_W(5), .N_SRC(24)) bif ();

    bus_arbiter #(
        .N_REQ(4), .SRC_W(5), .N_SRC(24), .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src();
        for (int i = 0; i < 4; i++) bif.req_src[i*5 +: 5] = 5'(src_tab[i]);
    endtask

    task automatic do_clr();
        clr     = 1'b1;
        bif.req = 4'b0000;
        cyc();
        clr = 1'b0;
    endtask

    // Packed view {gnt, bus_out_en, busy, timeout, bad_src}
    function automatic logic [30:0] obs();
        return {bif.gnt, bif.bus_out_en, bif.busy, bif.timeout, bif.bad_src};
    endfunction

    function automatic logic [30:0] mk(input logic [3:0] g, input logic tmo);
        logic [23:0] en;
        logic        bad;
        en  = '0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                if (src_tab[i] < 24) en[src_tab[i]] = 1'b1;
                else bad = 1'b1;
            end
        end
        return {g, en, |g, tmo, bad};
    endfunction

    task automatic test_reset();
        logic [3:0] r [3] = '{4'b0000, 4'b1111, 4'b0000};
        logic       c [3] = '{1'b1, 1'b1, 1'b0};
        logic [30:0] e;
        src_tab = '{0, 1, 2, 3};
        set_src();
        for (int i = 0; i < 3; i++) begin
            clr     = c[i];
            bif.req = r[i];
            sb.push_back(mk(4'b0000, 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL reset step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [3:0] r [2] = '{4'b0001, 4'b0000};
        logic [3:0] g [2] = '{4'b0001, 4'b0000};
        logic [30:0] e;
        src_tab = '{3, 9, 10, 11};
        set_src();
        do_clr();
        for (int i = 0; i < 2; i++) begin
            bif.req = r[i];
            sb.push_back(mk(g[i], 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL single step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r [6] = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [3:0] g [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [30:0] e;
        src_tab = '{20, 21, 22, 23};
        set_src();
        do_clr();
        for (int i = 0; i < 6; i++) begin
            bif.req = r[i];
            sb.push_back(mk(g[i], 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL back_to_back step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_preempt();
        logic [3:0] r [8] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101,
                              4'b0101, 4'b0101, 4'b0001, 4'b0000};
        logic [3:0] g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic       t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [30:0] e;
        src_tab = '{1, 2, 16, 17};
        set_src();
        do_clr();
        for (int i = 0; i < 8; i++) begin
            bif.req = r[i];
            sb.push_back(mk(g[i], t[i]));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL preempt step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_lone_hold();
        logic [30:0] e;
        src_tab = '{0, 18, 2, 3};
        set_src();
        do_clr();
        for (int i = 0; i < 51; i++) begin
            bif.req = (i < 50) ? 4'b0010 : 4'b0000;
            sb.push_back(mk((i < 50) ? 4'b0010 : 4'b0000, 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL lone_hold step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_bad_src();
        logic [3:0] r [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] g [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [30:0] e;
        src_tab = '{24, 1, 2, 3};
        set_src();
        do_clr();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                src_tab[0] = 5;
                set_src();
            end
            bif.req = r[i];
            sb.push_back(mk(g[i], 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL bad_src step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
    endtask

    task automatic test_clr_mid_grant();
        logic [3:0] r [6] = '{4'b0010, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
        logic       c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] g [6] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000};
        logic [30:0] e;
        src_tab = '{4, 6, 7, 8};
        set_src();
        do_clr();
        for (int i = 0; i < 6; i++) begin
            clr     = c[i];
            bif.req = r[i];
            sb.push_back(mk(g[i], 1'b0));
            cyc();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL clr_mid_grant step %0d: got %h expected %h", i, obs(), e);
            else passed++;
        end
        clr = 1'b0;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        clr         = 1'b1;
        bif.req     = 4'b0000;
        bif.req_src = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_lone_hold();
        test_bad_src();
        test_clr_mid_grant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
